// File: rtl/cpu_stack_ctrl_if.sv
// Request bus from the instruction decoder and strobe bus to the MCS8 PC/address stack.
// The sequencer sits on the slave side; the decoder and stack side drives the master side.
interface cpu_stack_ctrl_if #(
    parameter int PTR_W = 3
);
    logic             REQ_I;
    logic [2:0]       OP_I;
    logic             COND_I;
    logic [13:0]      ADDR_I;
    logic [2:0]       RST_VEC_I;
    logic             CLR_ERR_I;
    logic [7:0]       STK_DAT_I;
    logic             ACK_O;
    logic             BUSY_O;
    logic             DONE_O;
    logic             SKIP_O;
    logic             STK_RD_O;
    logic             STK_WR_O;
    logic             STK_HA_O;
    logic             STK_INCR_O;
    logic             STK_PUSH_O;
    logic             STK_POP_O;
    logic [7:0]       STK_DAT_O;
    logic [13:0]      PC_O;
    logic [PTR_W-1:0] DEPTH_O;
    logic             OVF_O;
    logic             UNF_O;

    modport master (
        output REQ_I, OP_I, COND_I, ADDR_I, RST_VEC_I, CLR_ERR_I, STK_DAT_I,
        input  ACK_O, BUSY_O, DONE_O, SKIP_O, STK_RD_O, STK_WR_O, STK_HA_O,
               STK_INCR_O, STK_PUSH_O, STK_POP_O, STK_DAT_O, PC_O, DEPTH_O, OVF_O, UNF_O
    );

    modport slave (
        input  REQ_I, OP_I, COND_I, ADDR_I, RST_VEC_I, CLR_ERR_I, STK_DAT_I,
        output ACK_O, BUSY_O, DONE_O, SKIP_O, STK_RD_O, STK_WR_O, STK_HA_O,
               STK_INCR_O, STK_PUSH_O, STK_POP_O, STK_DAT_O, PC_O, DEPTH_O, OVF_O, UNF_O
    );
endinterface

// File: rtl/cpu_stack_ctrl.sv
// MCS8 PC-stack sequencer: expands one decoded control-flow op into ordered single-cycle
// stack strobes, and tracks nesting depth together with sticky overflow/underflow flags.
module cpu_stack_ctrl #(
    parameter int PTR_W = 3
) (
    input logic             CLK2_I,
    input logic             nRST_I,
    cpu_stack_ctrl_if.slave bus
);
    typedef enum logic [3:0] {
        S_IDLE, S_INC, S_PUSH, S_POP, S_WRL, S_WRH, S_RDL, S_RDH, S_FIN
    } state_e;

    typedef enum logic [2:0] {
        OP_NOP, OP_INC, OP_JMP, OP_CALL, OP_RET, OP_RST, OP_RDPC, OP_RSVD
    } op_e;

    localparam logic [PTR_W-1:0] DEPTH_MAX = '1;
    localparam logic [PTR_W-1:0] DEPTH_ONE = PTR_W'(1);

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic             cond_q, cond_d;
    logic [13:0]      addr_q, addr_d;
    logic [2:0]       vec_q, vec_d;
    logic [13:0]      pc_q, pc_d;
    logic [PTR_W-1:0] depth_q, depth_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             accept;
    logic [7:0]       wr_lo, wr_hi;
    logic             unused_dat;

    // A conditional op with a false condition collapses straight to FIN.
    function automatic state_e first_state(input op_e op, input logic cond);
        case (op)
            OP_INC:  return S_INC;
            OP_JMP:  return cond ? S_WRL : S_FIN;
            OP_CALL: return cond ? S_PUSH : S_FIN;
            OP_RET:  return cond ? S_POP : S_FIN;
            OP_RST:  return S_PUSH;
            OP_RDPC: return S_RDL;
            default: return S_FIN;
        endcase
    endfunction

    assign accept     = nRST_I && (state_q == S_IDLE) && bus.REQ_I;
    assign unused_dat = ^bus.STK_DAT_I[7:6];

    always_comb begin
        // NOTE: every next-state signal is defaulted first so no path through the case infers a latch.
        state_d = state_q;
        op_d    = op_q;
        cond_d  = cond_q;
        addr_d  = addr_q;
        vec_d   = vec_q;
        pc_d    = pc_q;
        depth_d = depth_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        if (bus.CLR_ERR_I) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d    = op_e'(bus.OP_I);
                    cond_d  = bus.COND_I;
                    addr_d  = bus.ADDR_I;
                    vec_d   = bus.RST_VEC_I;
                    state_d = first_state(op_e'(bus.OP_I), bus.COND_I);
                end
            end
            S_INC: state_d = S_FIN;
            S_PUSH: begin
                if (depth_q == DEPTH_MAX) ovf_d = 1'b1;
                depth_d = depth_q + DEPTH_ONE;
                state_d = S_WRL;
            end
            S_POP: begin
                if (depth_q == '0) unf_d = 1'b1;
                depth_d = depth_q - DEPTH_ONE;
                state_d = S_FIN;
            end
            S_WRL: state_d = S_WRH;
            S_WRH: state_d = S_FIN;
            S_RDL: begin
                pc_d[7:0] = bus.STK_DAT_I;
                state_d   = S_RDH;
            end
            S_RDH: begin
                pc_d[13:8] = bus.STK_DAT_I[5:0];
                state_d    = S_FIN;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK2_I) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!nRST_I) begin
            state_q <= S_IDLE;
            op_q    <= OP_NOP;
            cond_q  <= 1'b0;
            addr_q  <= '0;
            vec_q   <= '0;
            pc_q    <= '0;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cond_q  <= cond_d;
            addr_q  <= addr_d;
            vec_q   <= vec_d;
            pc_q    <= pc_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Restart writes the fixed vector page address AAA*8 instead of the operand.
    assign wr_lo = (op_q == OP_RST) ? {2'b00, vec_q, 3'b000} : addr_q[7:0];
    assign wr_hi = (op_q == OP_RST) ? 8'h00 : {2'b00, addr_q[13:8]};

    assign bus.ACK_O      = accept;
    assign bus.BUSY_O     = (state_q != S_IDLE);
    assign bus.DONE_O     = (state_q == S_FIN);
    assign bus.SKIP_O     = (state_q == S_FIN) && !cond_q &&
                            ((op_q == OP_JMP) || (op_q == OP_CALL) || (op_q == OP_RET));
    assign bus.STK_INCR_O = (state_q == S_INC);
    assign bus.STK_PUSH_O = (state_q == S_PUSH);
    assign bus.STK_POP_O  = (state_q == S_POP);
    assign bus.STK_WR_O   = (state_q == S_WRL) || (state_q == S_WRH);
    assign bus.STK_RD_O   = (state_q == S_RDL) || (state_q == S_RDH);
    assign bus.STK_HA_O   = (state_q == S_WRH) || (state_q == S_RDH);
    assign bus.STK_DAT_O  = (state_q == S_WRL) ? wr_lo :
                            (state_q == S_WRH) ? wr_hi : 8'h00;
    assign bus.PC_O       = pc_q;
    assign bus.DEPTH_O    = depth_q;
    assign bus.OVF_O      = ovf_q;
    assign bus.UNF_O      = unf_q;
endmodule

// File: tb/tb_cpu_stack_ctrl.sv
// Self-checking bench for cpu_stack_ctrl: directed table, hand-written corner sequences,
// and random ops compared against a per-operation strobe/depth model.
module tb_cpu_stack_ctrl;
    localparam int PTR_W  = 3;
    localparam int DEPTHS = 1 << PTR_W;

    // Observed word layout: {ACK, BUSY, DONE, SKIP, RD, WR, HA, INCR, PUSH, POP, DAT[7:0]}
    localparam logic [17:0] A_ACK  = 18'h20000;
    localparam logic [17:0] A_BUSY = 18'h10000;
    localparam logic [17:0] A_DONE = 18'h08000;
    localparam logic [17:0] A_SKIP = 18'h04000;
    localparam logic [17:0] A_RD   = 18'h02000;
    localparam logic [17:0] A_WR   = 18'h01000;
    localparam logic [17:0] A_HA   = 18'h00800;
    localparam logic [17:0] A_INCR = 18'h00400;
    localparam logic [17:0] A_PUSH = 18'h00200;
    localparam logic [17:0] A_POP  = 18'h00100;

    typedef struct {
        logic [2:0]  op;
        logic        cond;
        logic [13:0] addr;
        logic [2:0]  vec;
        logic [7:0]  lo;
        logic [7:0]  hi;
        int          len;
        int          depth;
        logic [13:0] pc;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    int          m_depth;
    bit          m_ovf, m_unf;
    logic [13:0] m_pc;

    always #5 clk = ~clk;

    cpu_stack_ctrl_if #(.PTR_W(PTR_W)) bus ();

    cpu_stack_ctrl #(.PTR_W(PTR_W)) dut (
        .CLK2_I (clk),
        .nRST_I (rst_n),
        .bus    (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [17:0] obs();
        return {bus.ACK_O, bus.BUSY_O, bus.DONE_O, bus.SKIP_O, bus.STK_RD_O, bus.STK_WR_O,
                bus.STK_HA_O, bus.STK_INCR_O, bus.STK_PUSH_O, bus.STK_POP_O, bus.STK_DAT_O};
    endfunction

    task automatic check_state(input string tag);
        check({tag, " depth"}, 32'(bus.DEPTH_O), 32'(m_depth));
        check({tag, " ovf"},   32'(bus.OVF_O),   32'(m_ovf));
        check({tag, " unf"},   32'(bus.UNF_O),   32'(m_unf));
        check({tag, " pc"},    32'(bus.PC_O),    32'(m_pc));
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        bus.REQ_I     = 1'b0;
        bus.OP_I      = 3'd0;
        bus.COND_I    = 1'b0;
        bus.ADDR_I    = 14'h0;
        bus.RST_VEC_I = 3'd0;
        bus.CLR_ERR_I = 1'b0;
        bus.STK_DAT_I = 8'h00;
        @(posedge clk); #1;
        @(posedge clk); #1;
        m_depth = 0; m_ovf = 1'b0; m_unf = 1'b0; m_pc = 14'h0;
        @(negedge clk);
        check("reset outputs", 32'(obs()), 32'h0);
        check_state("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic idle_cycle(input bit clr);
        bus.REQ_I     = 1'b0;
        bus.OP_I      = 3'($urandom);
        bus.CLR_ERR_I = clr;
        @(negedge clk);
        check("idle outputs", 32'(obs()), 32'h0);
        @(posedge clk); #1;
        bus.CLR_ERR_I = 1'b0;
        if (clr) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        check("idle ovf", 32'(bus.OVF_O), 32'(m_ovf));
        check("idle unf", 32'(bus.UNF_O), 32'(m_unf));
    endtask

    // clr_at: -1 none, -2 random cycle, otherwise index of the post-accept cycle carrying CLR_ERR_I.
    task automatic run_op(input logic [2:0] op, input logic cond, input logic [13:0] addr,
                          input logic [2:0] vec, input logic [7:0] lo, input logic [7:0] hi,
                          input bit noisy, input int clr_at, output int done_at);
        logic [17:0] seq[$];
        bit          cond_op, taken;
        logic [7:0]  wlo, whi;
        int          clr_i;
        cond_op = (op == 3'd2) || (op == 3'd3) || (op == 3'd4);
        taken   = !cond_op || cond;
        wlo     = (op == 3'd5) ? 8'(int'(vec) * 8) : addr[7:0];
        whi     = (op == 3'd5) ? 8'h00 : 8'(int'(addr) / 256);
        if (op == 3'd1) seq.push_back(A_BUSY | A_INCR);
        if (taken && (op == 3'd3 || op == 3'd5)) seq.push_back(A_BUSY | A_PUSH);
        if (taken && (op == 3'd2 || op == 3'd3 || op == 3'd5)) begin
            seq.push_back(A_BUSY | A_WR | {10'h0, wlo});
            seq.push_back(A_BUSY | A_WR | A_HA | {10'h0, whi});
        end
        if (taken && op == 3'd4) seq.push_back(A_BUSY | A_POP);
        if (op == 3'd6) begin
            seq.push_back(A_BUSY | A_RD);
            seq.push_back(A_BUSY | A_RD | A_HA);
        end
        seq.push_back(A_BUSY | A_DONE | (taken ? 18'h0 : A_SKIP));
        clr_i = clr_at;
        if (clr_at == -2)
            clr_i = ($urandom % 3 == 0) ? int'($urandom_range(0, seq.size() - 1)) : -1;

        bus.REQ_I     = 1'b1;
        bus.OP_I      = op;
        bus.COND_I    = cond;
        bus.ADDR_I    = addr;
        bus.RST_VEC_I = vec;
        bus.STK_DAT_I = 8'($urandom);
        @(negedge clk);
        check("accept", 32'(obs()), 32'(A_ACK));
        @(posedge clk); #1;

        done_at = 0;
        for (int i = 0; i < seq.size(); i++) begin
            if (noisy) begin
                bus.REQ_I     = 1'($urandom);
                bus.OP_I      = 3'($urandom);
                bus.COND_I    = 1'($urandom);
                bus.ADDR_I    = 14'($urandom);
                bus.RST_VEC_I = 3'($urandom);
            end else begin
                bus.REQ_I = 1'b0;
            end
            bus.CLR_ERR_I = (i == clr_i);
            if ((seq[i] & A_RD) != 18'h0)
                bus.STK_DAT_I = ((seq[i] & A_HA) != 18'h0) ? hi : lo;
            else
                bus.STK_DAT_I = 8'($urandom);
            @(negedge clk);
            check("strobes", 32'(obs()), 32'(seq[i]));
            if (bus.DONE_O && done_at == 0) done_at = i + 1;
            @(posedge clk); #1;
            if (i == clr_i) begin
                m_ovf = 1'b0;
                m_unf = 1'b0;
            end
            if ((seq[i] & A_PUSH) != 18'h0) begin
                if (m_depth == DEPTHS - 1) m_ovf = 1'b1;
                m_depth = (m_depth + 1) % DEPTHS;
            end
            if ((seq[i] & A_POP) != 18'h0) begin
                if (m_depth == 0) m_unf = 1'b1;
                m_depth = (m_depth + DEPTHS - 1) % DEPTHS;
            end
        end
        bus.REQ_I     = 1'b0;
        bus.CLR_ERR_I = 1'b0;
        if (op == 3'd6) m_pc = 14'((int'(hi) % 64) * 256 + int'(lo));
        check_state("post-op");
    endtask

    initial begin
        vec_t tbl[14];
        int   done_at;
        logic [2:0] r_op;

        tbl[0]  = '{3'd3, 1'b1, 14'h1234, 3'd0, 8'h00, 8'h00, 4, 1, 14'h0000};
        tbl[1]  = '{3'd4, 1'b0, 14'h0000, 3'd0, 8'h00, 8'h00, 1, 1, 14'h0000};
        tbl[2]  = '{3'd4, 1'b1, 14'h0000, 3'd0, 8'h00, 8'h00, 2, 0, 14'h0000};
        tbl[3]  = '{3'd5, 1'b0, 14'h3FFF, 3'd5, 8'h00, 8'h00, 4, 1, 14'h0000};
        tbl[4]  = '{3'd6, 1'b0, 14'h0000, 3'd0, 8'h28, 8'h00, 3, 1, 14'h0028};
        tbl[5]  = '{3'd2, 1'b1, 14'h3FFF, 3'd0, 8'h00, 8'h00, 3, 1, 14'h0028};
        tbl[6]  = '{3'd2, 1'b0, 14'h1111, 3'd0, 8'h00, 8'h00, 1, 1, 14'h0028};
        tbl[7]  = '{3'd1, 1'b0, 14'h0000, 3'd0, 8'h00, 8'h00, 2, 1, 14'h0028};
        tbl[8]  = '{3'd0, 1'b1, 14'h2222, 3'd0, 8'h00, 8'h00, 1, 1, 14'h0028};
        tbl[9]  = '{3'd7, 1'b1, 14'h3333, 3'd0, 8'h00, 8'h00, 1, 1, 14'h0028};
        tbl[10] = '{3'd6, 1'b1, 14'h0000, 3'd0, 8'hA5, 8'hFF, 3, 1, 14'h3FA5};
        tbl[11] = '{3'd3, 1'b0, 14'h0ABC, 3'd0, 8'h00, 8'h00, 1, 1, 14'h3FA5};
        tbl[12] = '{3'd3, 1'b1, 14'h2A55, 3'd0, 8'h00, 8'h00, 4, 2, 14'h3FA5};
        tbl[13] = '{3'd5, 1'b1, 14'h0000, 3'd7, 8'h00, 8'h00, 4, 3, 14'h3FA5};

        do_reset();
        for (int k = 0; k < 14; k++) begin
            run_op(tbl[k].op, tbl[k].cond, tbl[k].addr, tbl[k].vec, tbl[k].lo, tbl[k].hi,
                   1'b1, -1, done_at);
            check("table latency", 32'(done_at), 32'(tbl[k].len));
            check("table depth", 32'(bus.DEPTH_O), 32'(tbl[k].depth));
            check("table pc", 32'(bus.PC_O), 32'(tbl[k].pc));
        end

        // Eight nested calls wrap the depth and flag overflow only on the last one.
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            run_op(3'd3, 1'b1, 14'(k * 16'h0101), 3'd0, 8'h00, 8'h00, 1'b0, -1, done_at);
            check("nest ovf", 32'(bus.OVF_O), (k == 8) ? 32'd1 : 32'd0);
            check("nest depth", 32'(bus.DEPTH_O), 32'(k % 8));
        end
        run_op(3'd4, 1'b1, 14'h0, 3'd0, 8'h00, 8'h00, 1'b0, -1, done_at);
        check("ret at empty unf", 32'(bus.UNF_O), 32'd1);
        check("ret at empty depth", 32'(bus.DEPTH_O), 32'd7);
        idle_cycle(1'b1);
        check("clear ovf", 32'(bus.OVF_O), 32'd0);
        check("clear unf", 32'(bus.UNF_O), 32'd0);
        // Clear coinciding with the overflowing push: the set must win.
        run_op(3'd3, 1'b1, 14'h0777, 3'd0, 8'h00, 8'h00, 1'b0, 0, done_at);
        check("set beats clear ovf", 32'(bus.OVF_O), 32'd1);
        check("set beats clear depth", 32'(bus.DEPTH_O), 32'd0);

        // REQ held with INC: one op every three cycles; OP changes while busy are ignored.
        for (int c = 0; c < 9; c++) begin
            bus.REQ_I = 1'b1;
            bus.OP_I  = (c % 3 == 0) ? 3'd1 : 3'($urandom);
            @(negedge clk);
            check("b2b ack",  32'(bus.ACK_O),      (c % 3 == 0) ? 32'd1 : 32'd0);
            check("b2b incr", 32'(bus.STK_INCR_O), (c % 3 == 1) ? 32'd1 : 32'd0);
            check("b2b done", 32'(bus.DONE_O),     (c % 3 == 2) ? 32'd1 : 32'd0);
            @(posedge clk); #1;
        end
        bus.REQ_I = 1'b0;
        check_state("b2b");

        // Reset asserted during WRL of a JMP: no WRH follows.
        bus.REQ_I  = 1'b1;
        bus.OP_I   = 3'd2;
        bus.COND_I = 1'b1;
        bus.ADDR_I = 14'h2BCD;
        @(negedge clk);
        check("jmp accept", 32'(bus.ACK_O), 32'd1);
        @(posedge clk); #1;
        bus.REQ_I = 1'b0;
        @(negedge clk);
        check("jmp wrl", 32'(obs()), 32'(A_BUSY | A_WR | 18'h000CD));
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_depth = 0; m_ovf = 1'b0; m_unf = 1'b0; m_pc = 14'h0;
        @(negedge clk);
        check("abort no wrh", 32'(obs()), 32'h0);
        check_state("abort");
        @(posedge clk); #1;

        // Random ops against the model.
        for (int n = 0; n < 300; n++) begin
            if ($urandom % 4 == 0) idle_cycle($urandom % 3 == 0);
            r_op = 3'($urandom);
            run_op(r_op, ($urandom % 4) != 0, 14'($urandom), 3'($urandom), 8'($urandom),
                   8'($urandom), 1'b1, -2, done_at);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
